// File: rtl/lcd_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] DIGIT_MAX = 7'd99;

    // Two decimal digits cannot show more than 99, so larger values are pinned there.
    function automatic logic [6:0] sat7(input logic [6:0] x);
        return (x > DIGIT_MAX) ? DIGIT_MAX : x;
    endfunction

endpackage

// File: rtl/lcd_scan_ctrl_if.sv
// Signal bundle between the scan controller, its request source, the shared converter and the display.
interface lcd_scan_ctrl_if #(
    parameter int NCH = 3
);
    import lcd_pkg::*;

    // Load is a level-sampled request with no ready: while Busy it is only remembered
    // (coalesced into one extra pass); Done pulses for one cycle when every channel is updated.
    logic               Load;
    logic [NCH*7-1:0]   Bin;
    logic [6:0]         Conv_bin;
    logic [6:0]         Conv_seg1;
    logic [6:0]         Conv_seg0;
    logic [NCH*7-1:0]   Seg1;
    logic [NCH*7-1:0]   Seg0;
    logic [NCH-1:0]     Ovf;
    logic               Busy;
    logic               Done;
    state_t             dbg_state;

    modport slave (
        input  Load, Bin, Conv_seg1, Conv_seg0,
        output Conv_bin, Seg1, Seg0, Ovf, Busy, Done, dbg_state
    );

    modport master (
        output Load, Bin, Conv_seg1, Conv_seg0,
        input  Conv_bin, Seg1, Seg0, Ovf, Busy, Done, dbg_state
    );

endinterface

// File: rtl/lcd_scan_ctrl.sv
// Time-shares one external binary->7-seg converter among NCH channels from a coherent snapshot.
// Optional build macro BLANK_LEADING_ZERO_EN blanks the tens digit for values below 10.
module lcd_scan_ctrl
    import lcd_pkg::*;
#(
    parameter int NCH    = 3,
    parameter int SETTLE = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    lcd_scan_ctrl_if.slave   bus
);

    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state_q, state_d;
    logic [CHW-1:0]  ch_q;
    logic [CNTW-1:0] cnt_q;
    logic            pending_q;
    logic [6:0]      snap_q [NCH];
    logic [6:0]      seg1_q [NCH];
    logic [6:0]      seg0_q [NCH];
    logic [NCH-1:0]  ovf_q;

    logic            snap_en;
    logic            capt_en;
    logic            last_ch;
    logic            settle_end;
    logic [6:0]      cur_val;

    assign last_ch    = (ch_q == CHW'(NCH - 1));
    assign settle_end = (cnt_q == CNTW'(SETTLE - 1));
    assign cur_val    = sat7(snap_q[ch_q]);

    always_comb begin
        state_d = state_q;
        snap_en = 1'b0;
        capt_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Load) begin
                    snap_en = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_end) state_d = CAPT;
            end
            CAPT: begin
                capt_en = 1'b1;
                state_d = last_ch ? DONE : DRIVE;
            end
            DONE: begin
                if (pending_q || bus.Load) begin
                    snap_en = 1'b1;
                    state_d = DRIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            cnt_q     <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (snap_en) begin
                ch_q  <= '0;
                cnt_q <= '0;
            end else if (state_q == DRIVE) begin
                if (!settle_end) cnt_q <= cnt_q + 1'b1;
            end else if (state_q == CAPT) begin
                cnt_q <= '0;
                if (!last_ch) ch_q <= ch_q + 1'b1;
            end
            // A request arriving in DONE starts the next pass directly, so DONE only clears.
            if (state_q == DONE) begin
                pending_q <= 1'b0;
            end else if ((state_q == DRIVE || state_q == CAPT) && bus.Load) begin
                pending_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                snap_q[i] <= '0;
                seg1_q[i] <= SEG_BLANK;
                seg0_q[i] <= SEG_BLANK;
            end
            ovf_q <= '0;
        end else begin
            if (snap_en) begin
                for (int i = 0; i < NCH; i++) snap_q[i] <= bus.Bin[7*i +: 7];
            end
            if (capt_en) begin
`ifdef BLANK_LEADING_ZERO_EN
                seg1_q[ch_q] <= (cur_val < 7'd10) ? SEG_BLANK : bus.Conv_seg1;
`else
                seg1_q[ch_q] <= bus.Conv_seg1;
`endif
                seg0_q[ch_q] <= bus.Conv_seg0;
                ovf_q[ch_q]  <= (snap_q[ch_q] > DIGIT_MAX);
            end
        end
    end

    // The converter input must stay valid through CAPT, where its outputs are latched.
    assign bus.Conv_bin  = (state_q == DRIVE || state_q == CAPT) ? cur_val : 7'd0;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = (state_q == DONE);
    assign bus.dbg_state = state_q;
    assign bus.Ovf       = ovf_q;

    for (genvar i = 0; i < NCH; i++) begin : g_out
        assign bus.Seg1[7*i +: 7] = seg1_q[i];
        assign bus.Seg0[7*i +: 7] = seg0_q[i];
    end

endmodule
